// File: rtl/bg_tile_fetcher.sv
// rtl/bg_tile_fetcher.sv - background tile fetcher: map/lo/hi VRAM reads, one tile per handshake
module bg_tile_fetcher #(
    parameter int TILES_PER_LINE = 21
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic        line_abort,
    input  logic [7:0]  scx,
    input  logic [7:0]  scy,
    input  logic [7:0]  ly,
    input  logic        map_sel,
    input  logic        data_sel,
    output logic [12:0] vram_addr,
    output logic        vram_rd,
    input  logic        vram_gnt,
    input  logic [7:0]  vram_data,
    output logic [7:0]  tile_lo,
    output logic [7:0]  tile_hi,
    output logic        tile_valid,
    input  logic        tile_ready,
    output logic        busy,
    output logic        line_done
);

    typedef enum logic [2:0] {
        IDLE,
        MAP_REQ,
        MAP_WAIT,
        LO_REQ,
        LO_WAIT,
        HI_REQ,
        HI_WAIT,
        PUSH
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  tx;
    logic [4:0]  ty;
    logic [2:0]  fy;
    logic [5:0]  cnt;
    logic [7:0]  lo_byte;
    logic [7:0]  yy;
    logic [4:0]  tx_line;
    logic [4:0]  tx_src;
    logic [4:0]  ty_src;
    logic [12:0] addr_next;
    logic        accept;
    logic        last_tile;
    logic        done_next;
    logic        b12;

    assign yy         = scy + ly;
    assign tx_line    = 5'((scx & 8'hF8) >> 3);
    assign vram_rd    = (state == MAP_REQ) || (state == LO_REQ) || (state == HI_REQ);
    assign tile_valid = (state == PUSH);
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        addr_next  = vram_addr;
        done_next  = 1'b0;
        accept     = (state == PUSH) && tile_ready;
        last_tile  = (cnt == 6'(TILES_PER_LINE - 1));
        tx_src     = line_start ? tx_line : (accept ? tx + 5'd1 : tx);
        ty_src     = line_start ? yy[7:3] : ty;
        // Signed tile numbers index around 0x1000: negative numbers land in 0x0800..0x0FFF.
        b12        = data_sel ? 1'b0 : ~vram_data[7];

        case (state)
            IDLE:     if (line_start) state_next = MAP_REQ;
            MAP_REQ:  if (vram_gnt) state_next = MAP_WAIT;
            MAP_WAIT: state_next = LO_REQ;
            LO_REQ:   if (vram_gnt) state_next = LO_WAIT;
            LO_WAIT:  state_next = HI_REQ;
            HI_REQ:   if (vram_gnt) state_next = HI_WAIT;
            HI_WAIT:  state_next = PUSH;
            PUSH: begin
                if (accept) begin
                    if (last_tile) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = MAP_REQ;
                    end
                end
            end
            default:  state_next = IDLE;
        endcase

        if (line_start) state_next = MAP_REQ;
        if (line_abort) begin
            state_next = IDLE;
            done_next  = 1'b0;
        end

        // Address is computed once on entry to a request state so it stays put while stalled.
        if (state_next == MAP_REQ && (line_start || state == PUSH)) begin
            addr_next = {2'b11, map_sel, ty_src, tx_src};
        end else if (state == MAP_WAIT && state_next == LO_REQ) begin
            addr_next = {b12, vram_data, fy, 1'b0};
        end else if (state == LO_WAIT && state_next == HI_REQ) begin
            addr_next = {vram_addr[12:1], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            vram_addr <= 13'd0;
            line_done <= 1'b0;
            tx        <= 5'd0;
            ty        <= 5'd0;
            fy        <= 3'd0;
            cnt       <= 6'd0;
            lo_byte   <= 8'd0;
            tile_lo   <= 8'd0;
            tile_hi   <= 8'd0;
        end else begin
            state     <= state_next;
            vram_addr <= addr_next;
            line_done <= done_next;
            if (line_start && !line_abort) begin
                ty  <= yy[7:3];
                fy  <= yy[2:0];
                tx  <= tx_line;
                cnt <= 6'd0;
            end else if (accept && !line_abort) begin
                tx  <= tx + 5'd1;
                cnt <= cnt + 6'd1;
            end
            if (state == LO_WAIT) lo_byte <= vram_data;
            if (state == HI_WAIT && state_next == PUSH) begin
                tile_lo <= lo_byte;
                tile_hi <= vram_data;
            end
        end
    end

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// tb/tb_bg_tile_fetcher.sv - directed vector bench for bg_tile_fetcher
module tb_bg_tile_fetcher;

    logic        clk = 1'b0;
    logic        reset, line_start, line_abort;
    logic [7:0]  scx, scy, ly;
    logic        map_sel, data_sel;
    logic [12:0] vram_addr;
    logic        vram_rd, vram_gnt;
    logic [7:0]  vram_data = 8'd0;
    logic [7:0]  tile_lo, tile_hi;
    logic        tile_valid, tile_ready, busy, line_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:8191];

    bg_tile_fetcher #(.TILES_PER_LINE(21)) dut (
        .clk(clk), .reset(reset), .line_start(line_start), .line_abort(line_abort),
        .scx(scx), .scy(scy), .ly(ly), .map_sel(map_sel), .data_sel(data_sel),
        .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_gnt(vram_gnt), .vram_data(vram_data),
        .tile_lo(tile_lo), .tile_hi(tile_hi), .tile_valid(tile_valid), .tile_ready(tile_ready),
        .busy(busy), .line_done(line_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vram_rd && vram_gnt) vram_data <= mem[vram_addr];
    end

    typedef struct {
        logic [7:0]  scx, scy, ly;
        logic        map_sel, data_sel;
        logic [7:0]  map_byte;
        logic [12:0] exp_map, exp_lo, exp_hi;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [7:0] pat(input logic [12:0] a);
        return a[7:0] ^ {3'b000, a[12:8]} ^ 8'hA5;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic abort_line;
        line_abort = 1'b1;
        tick;
        line_abort = 1'b0;
        tick;
    endtask

    task automatic basic_cfg;
        scx = 8'h00; scy = 8'h00; ly = 8'h00; map_sel = 1'b0; data_sel = 1'b1;
        vram_gnt = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!tile_valid && n < 40) begin
            tick;
            n++;
        end
        check(name, {31'd0, tile_valid}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [12:0] got [3];
        int g = 0;
        int n = 0;
        scx = v.scx; scy = v.scy; ly = v.ly; map_sel = v.map_sel; data_sel = v.data_sel;
        mem[v.exp_map] = v.map_byte;
        vram_gnt = 1'b1; tile_ready = 1'b0;
        line_start = 1'b1;
        tick;
        line_start = 1'b0;
        got[0] = '0; got[1] = '0; got[2] = '0;
        while (!tile_valid && n < 40) begin
            if (vram_rd && vram_gnt && g < 3) begin
                got[g] = vram_addr;
                g++;
            end
            tick;
            n++;
        end
        check($sformatf("vec%0d map_addr", idx), 32'(got[0]), 32'(v.exp_map));
        check($sformatf("vec%0d lo_addr", idx), 32'(got[1]), 32'(v.exp_lo));
        check($sformatf("vec%0d hi_addr", idx), 32'(got[2]), 32'(v.exp_hi));
        check($sformatf("vec%0d tile_lo", idx), 32'(tile_lo), 32'(pat(v.exp_lo)));
        check($sformatf("vec%0d tile_hi", idx), 32'(tile_hi), 32'(pat(v.exp_hi)));
        abort_line;
    endtask

    task automatic run_line(input bit restart_at_end);
        int c = 1;
        int tiles = 0;
        int dones = 0;
        int first_v = 0;
        int done_c = 0;
        basic_cfg;
        tile_ready = 1'b1;
        line_start = 1'b1;
        tick;
        line_start = 1'b0;
        while (c <= 170) begin
            if (line_done) begin
                dones++;
                done_c = c;
            end
            if (tile_valid && first_v == 0) first_v = c;
            if (tile_valid && tile_ready) begin
                tiles++;
                if (restart_at_end && tiles == 21) begin
                    line_start = 1'b1;
                    tick;
                    line_start = 1'b0;
                    check("restart line_done", {31'd0, line_done}, 32'd1);
                    check("restart vram_rd", {31'd0, vram_rd}, 32'd1);
                    check("restart addr", 32'(vram_addr), 32'h1800);
                    check("restart tile_valid", {31'd0, tile_valid}, 32'd0);
                    abort_line;
                    break;
                end
            end
            tick;
            c++;
        end
        if (!restart_at_end) begin
            check("first_valid_cycle", 32'(first_v), 32'd7);
            check("tiles_delivered", 32'(tiles), 32'd21);
            check("line_done_count", 32'(dones), 32'd1);
            check("line_done_cycle", 32'(done_c), 32'd148);
            check("busy_after_line", {31'd0, busy}, 32'd0);
        end
        tile_ready = 1'b0;
    endtask

    initial begin
        logic [12:0] q [4];
        int g;
        int n;
        int bad;
        vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h05, 13'h1800, 13'h0050, 13'h0051};
        vecs[1] = '{8'h00, 8'h00, 8'h03, 1'b0, 1'b0, 8'h80, 13'h1800, 13'h0806, 13'h0807};
        vecs[2] = '{8'h00, 8'h00, 8'h03, 1'b0, 1'b0, 8'h7F, 13'h1800, 13'h17F6, 13'h17F7};
        vecs[3] = '{8'hF8, 8'hFC, 8'h10, 1'b1, 1'b1, 8'h12, 13'h1C3F, 13'h0128, 13'h0129};
        vecs[4] = '{8'h10, 8'h00, 8'h07, 1'b0, 1'b1, 8'hFF, 13'h1802, 13'h0FFE, 13'h0FFF};
        vecs[5] = '{8'h3F, 8'h01, 8'hFF, 1'b0, 1'b0, 8'h00, 13'h1807, 13'h1000, 13'h1001};

        for (int i = 0; i < 8192; i++) mem[i] = pat(13'(i));

        reset = 1'b1; line_start = 1'b0; line_abort = 1'b0;
        tile_ready = 1'b0;
        basic_cfg;
        tick;
        tick;
        check("reset vram_addr", 32'(vram_addr), 32'd0);
        check("reset vram_rd", {31'd0, vram_rd}, 32'd0);
        check("reset tile_valid", {31'd0, tile_valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset line_done", {31'd0, line_done}, 32'd0);
        check("reset tiles", {16'd0, tile_hi, tile_lo}, 32'd0);
        reset = 1'b0;
        tick;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        for (int i = 0; i < 32; i++) mem[13'h1800 + 13'(i)] = 8'h05;
        run_line(1'b0);
        run_line(1'b1);

        // map row wrap: tx 31 -> 0
        scx = 8'hF8; scy = 8'hFC; ly = 8'h10; map_sel = 1'b1; data_sel = 1'b1;
        vram_gnt = 1'b1; tile_ready = 1'b1;
        line_start = 1'b1;
        tick;
        line_start = 1'b0;
        g = 0; n = 0;
        q[0] = '0; q[1] = '0; q[2] = '0; q[3] = '0;
        while (g < 4 && n < 40) begin
            if (vram_rd && vram_gnt) begin
                q[g] = vram_addr;
                g++;
            end
            tick;
            n++;
        end
        check("wrap map0", 32'(q[0]), 32'h1C3F);
        check("wrap map1", 32'(q[3]), 32'h1C20);
        tile_ready = 1'b0;
        abort_line;

        // grant stall in LO_REQ, then ready stall in PUSH
        basic_cfg;
        line_start = 1'b1;
        tick;
        line_start = 1'b0;
        tick;
        vram_gnt = 1'b0;
        tick;
        for (int i = 0; i < 5; i++) begin
            check("gnt stall rd/addr", {18'd0, vram_rd, vram_addr}, {18'd0, 1'b1, 13'h0050});
            data_sel = ~data_sel;
            map_sel = ~map_sel;
            if (i < 4) tick;
        end
        data_sel = 1'b1; map_sel = 1'b0; vram_gnt = 1'b1;
        tick;
        wait_valid("stall wait_valid");
        for (int i = 0; i < 10; i++) begin
            check("ready stall tile", {15'd0, tile_valid, tile_hi, tile_lo},
                  {15'd0, 1'b1, pat(13'h0051), pat(13'h0050)});
            tick;
        end
        tile_ready = 1'b1;
        tick;
        tile_ready = 1'b0;
        check("after accept valid", {31'd0, tile_valid}, 32'd0);
        check("after accept addr", 32'(vram_addr), 32'h1801);
        abort_line;

        // abort in HI_WAIT
        basic_cfg;
        line_start = 1'b1;
        tick;
        line_start = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        line_abort = 1'b1;
        tick;
        line_abort = 1'b0;
        check("abort state", {29'd0, busy, vram_rd, tile_valid}, 32'd0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (tile_valid || line_done || busy) bad++;
            tick;
        end
        check("abort quiet", 32'(bad), 32'd0);

        // line_start while a tile is pending
        basic_cfg;
        line_start = 1'b1;
        tick;
        line_start = 1'b0;
        for (int i = 0; i < 6; i++) tick;
        check("push reached", {31'd0, tile_valid}, 32'd1);
        ly = 8'h08;
        line_start = 1'b1;
        tick;
        line_start = 1'b0;
        check("restart drop valid", {31'd0, tile_valid}, 32'd0);
        check("restart rd/addr", {18'd0, vram_rd, vram_addr}, {18'd0, 1'b1, 13'h1820});
        abort_line;

        // reset during LO_REQ
        basic_cfg;
        line_start = 1'b1;
        tick;
        line_start = 1'b0;
        tick;
        tick;
        check("pre-reset lo req", {18'd0, vram_rd, vram_addr}, {18'd0, 1'b1, 13'h0050});
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("midreset addr", 32'(vram_addr), 32'd0);
        check("midreset ctl", {28'd0, vram_rd, tile_valid, busy, line_done}, 32'd0);
        check("midreset tiles", {16'd0, tile_hi, tile_lo}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
